// File: rtl/processor_key_in.sv
// Avalon-MM input PIO for pushbuttons/switches: 2-FF synchronizer, per-bit
// debounce, edge capture with write-1-to-clear, and a masked interrupt.
module processor_key_in #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? '1 : '0;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  // Does an accepted transition old_lvl -> new_lvl count as a capturable edge?
  function automatic logic edge_match(input logic old_lvl, input logic new_lvl);
    logic hit;
    if (EDGE_TYPE == 0)      hit = old_lvl & ~new_lvl;
    else if (EDGE_TYPE == 1) hit = ~old_lvl & new_lvl;
    else                     hit = old_lvl ^ new_lvl;
    return hit;
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    return 32'(v);
  endfunction

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] stable_p2;
  logic [CNT_W-1:0] cnt_p2 [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic             wr_en;

  if (WIDTH < 32) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[31:WIDTH];
  end

  // Stage p0/p1: two-flop synchronizer on the raw pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= IDLE_VEC;
      sync_p1 <= IDLE_VEC;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: a bit is accepted once it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    differ   = sync_p1 ^ stable_p2;
    accept   = '0;
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i]   = differ[i] && (cnt_p2[i] == CNT_LAST);
      edge_set[i] = accept[i] && edge_match(stable_p2[i], sync_p1[i]);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        cnt_p2[g] <= '0;
      else if (!differ[g] || accept[g])
        cnt_p2[g] <= '0;
      else
        cnt_p2[g] <= cnt_p2[g] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stable_p2 <= IDLE_VEC;
    else
      stable_p2 <= stable_p2 ^ accept;
  end

  // Register file; a capture on the same edge as a clear keeps the bit set
  assign wr_en    = chipselect && !write_n;
  assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && (address == ADDR_MASK))
        irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = zext(stable_p2);
      ADDR_MASK: readdata = zext(irqmask);
      ADDR_EDGE: readdata = zext(edgecapture);
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_processor_key_in.sv
// Bench for processor_key_in: directed scenarios plus randomized traffic,
// checked against a window-based behavioural model of the debounced keys.
module tb_processor_key_in;

  localparam int W   = 3;
  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [W-1:0] in_port = 3'b111;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  processor_key_in #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(0), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: a key level is accepted when the last DEB synchronized samples
  // (pins as seen two edges earlier) all differ from the accepted level.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_ec, m_mask, m_acc, m_clr;
  bit           all_diff;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_stable = 3'b111;
      m_ec     = '0;
      m_mask   = '0;
      hist.delete();
      for (int j = 0; j < DEB + 2; j++) hist.push_back(3'b111);
    end else begin
      m_acc = '0;
      for (int i = 0; i < W; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (hist[hist.size() - 2 - j][i] == m_stable[i]) all_diff = 1'b0;
        m_acc[i] = all_diff;
      end
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_ec  = (m_ec & ~m_clr) | (m_acc & m_stable);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_stable = m_stable ^ m_acc;
      hist.push_back(in_port);
      if (hist.size() > 32) void'(hist.pop_front());
    end
  end

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0: return {29'd0, m_stable};
      2'd2: return {29'd0, m_mask};
      2'd3: return {29'd0, m_ec};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return |(m_ec & m_mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0; in_port = 3'b111;
    step(); step();
    reset_n = 1'b1;
    step();
    rd(2'd0, d); checks++;
    if (d !== 32'h7) begin errors++; $display("FAIL reset_data got %h want %h", d, 32'h7); end
    rd(2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want 0", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_edge got %h want 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
  endtask

  task automatic test_debounce_latency();
    logic [31:0] d;
    int n;
    in_port = 3'b110;
    n = 0;
    d = 32'h7;
    while (d[0] !== 1'b0 && n < 20) begin
      step(); n++;
      rd(2'd0, d); checks++;
      if (d !== m_rd(2'd0)) begin errors++; $display("FAIL latency_model got %h want %h", d, m_rd(2'd0)); end
    end
    checks++;
    if (n != DEB + 2) begin errors++; $display("FAIL latency_edges got %0d want %0d", n, DEB + 2); end
    repeat (4) step();
    rd(2'd0, d); checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL fall_data got %h want 6", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL fall_edge got %h want 1", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL fall_irq_masked got %b want 0", irq); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(2'd2, 32'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask got %b want 1", irq); end
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL edge_cleared got %h want 0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port = 3'b100;
    repeat (3) step();
    in_port = 3'b110;
    repeat (10) begin
      step();
      rd(2'd0, d); checks++;
      if (d !== 32'h6) begin errors++; $display("FAIL glitch_data got %h want 6", d); end
    end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL glitch_edge got %h want 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq got %b want 0", irq); end
  endtask

  task automatic test_set_wins();
    logic [31:0] d;
    bus_write(2'd2, 32'h4);
    in_port = 3'b010;
    repeat (5) step();
    rd(2'd0, d); checks++;
    if (d !== 32'h6) begin errors++; $display("FAIL pre_capture_data got %h want 6", d); end
    bus_write(2'd3, 32'h4);
    rd(2'd0, d); checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL capture_data got %h want 2", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL set_wins_edge got %h want 4", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL set_wins_irq got %b want 1", irq); end
  endtask

  task automatic test_rise();
    logic [31:0] d;
    bus_write(2'd3, 32'h7);
    in_port = 3'b011;
    repeat (10) step();
    rd(2'd0, d); checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL rise_data got %h want 3", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rise_no_capture got %h want 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq got %b want 0", irq); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    int hold;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'($urandom); write_n = 1'b0;
        address = 2'($urandom); writedata = $urandom;
      end else begin
        chipselect = 1'b0; write_n = 1'b1; address = 2'($urandom);
      end
      step();
      #1;
      d = readdata;
      checks++;
      if (d !== m_rd(address)) begin
        errors++; $display("FAIL rand_read addr %0d got %h want %h", address, d, m_rd(address));
      end
      checks++;
      if (irq !== m_irq()) begin errors++; $display("FAIL rand_irq got %b want %b", irq, m_irq()); end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(2'd2, 32'h7);
    in_port = 3'b111;
    repeat (10) step();
    in_port = 3'b000;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    rd(2'd0, d); checks++;
    if (d !== 32'h7) begin errors++; $display("FAIL rst_mid_data got %h want 7", d); end
    rd(2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_mask got %h want 0", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_edge got %h want 0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %b want 0", irq); end
    step();
    reset_n = 1'b1;
    repeat (3) begin
      step();
      rd(2'd0, d); checks++;
      if (d !== 32'h7) begin errors++; $display("FAIL rst_discard_data got %h want 7", d); end
    end
    repeat (4) step();
    rd(2'd0, d); checks++;
    if (d !== m_rd(2'd0)) begin errors++; $display("FAIL rst_after_data got %h want %h", d, m_rd(2'd0)); end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_irq();
    test_glitch();
    test_set_wins();
    test_rise();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
